// File: rtl/hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl
// Pipeline interlock controller for the 5-stage MIPS core.
//   - Detects load-use hazards that forwarding cannot cover.
//   - Launches and tracks the shared multi-cycle multiply/divide unit, and
//     holds ID while a mult/div/mfhi/mflo would collide with a busy unit.
//   - Drives PC / IF-ID write enables and the ID/EX bubble.
//   - Keeps a saturating 16-bit count of stall cycles for bring-up.
//
// Ports
//   clk, rst                 core clock (rising edge), async active-high reset
//   id_valid, id_rs, id_rt   ID instruction and its source registers
//   id_uses_rs, id_uses_rt   ID instruction actually reads rs / rt
//   id_md_op                 00 none, 01 mult, 10 div, 11 reserved (none)
//   id_md_read               ID instruction is mfhi/mflo
//   ex_wreg, ex_m2reg, ex_rd EX writeback info (m2reg = load)
//   flush                    squash the ID instruction
//   pc_we, ifid_we           front-end write enables
//   idex_bubble              insert a NOP into ID/EX
//   md_start                 launch pulse to the mult/div unit
//   md_is_div                op of the current/last launch
//   md_busy, md_done         unit occupied / one-cycle result-ready pulse
//   stall_cycles             saturating stall-cycle counter
// -----------------------------------------------------------------------------
module hazard_stall_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic [1:0]  id_md_op,
    input  logic        id_md_read,
    input  logic        ex_wreg,
    input  logic        ex_m2reg,
    input  logic [4:0]  ex_rd,
    input  logic        flush,
    output logic        pc_we,
    output logic        ifid_we,
    output logic        idex_bubble,
    output logic        md_start,
    output logic        md_is_div,
    output logic        md_busy,
    output logic        md_done,
    output logic [15:0] stall_cycles
);

    typedef enum logic {MD_IDLE, MD_RUN} md_state_t;

    // Counter reload values: busy lasts LAT cycles counting LAT-1 down to 0.
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

    md_state_t        r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_is_div, w_is_div_nxt;
    logic             r_done, w_done_nxt;
    logic [15:0]      r_stall_cnt;

    logic w_md_op;
    logic w_is_div_op;
    logic w_rs_hit;
    logic w_rt_hit;
    logic w_load_use;
    logic w_md_hazard;
    logic w_stall;
    logic w_start;

    // ---------------- hazard detection (purely combinational) ----------------
    assign w_is_div_op = (id_md_op == 2'b10);
    assign w_md_op     = (id_md_op == 2'b01) | w_is_div_op;

    assign w_rs_hit   = id_uses_rs & (ex_rd == id_rs);
    assign w_rt_hit   = id_uses_rt & (ex_rd == id_rt);
    // r0 is hard-wired zero, so a load "to r0" never produces a dependency.
    assign w_load_use = id_valid & ex_wreg & ex_m2reg & (ex_rd != 5'd0)
                      & (w_rs_hit | w_rt_hit);

    // md_done cycle has md_busy low, so mfhi/mflo and a new launch pass then.
    assign w_md_hazard = id_valid & (r_state == MD_RUN) & (w_md_op | id_md_read);

    assign w_stall = (w_load_use | w_md_hazard) & ~flush;
    assign w_start = id_valid & w_md_op & ~w_stall & ~flush;

    assign pc_we       = ~w_stall;
    assign ifid_we     = ~w_stall;
    assign idex_bubble = w_stall | flush;
    assign md_start    = w_start;

    // ---------------- multiply/divide sequencer ----------------
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_is_div_nxt = r_is_div;
        w_done_nxt   = 1'b0;
        case (r_state)
            MD_IDLE: begin
                if (w_start) begin
                    w_state_nxt  = MD_RUN;
                    w_cnt_nxt    = w_is_div_op ? DIV_LOAD : MUL_LOAD;
                    w_is_div_nxt = w_is_div_op;
                end
            end
            MD_RUN: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_state_nxt = MD_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= MD_IDLE;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_is_div <= w_is_div_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign md_busy   = (r_state == MD_RUN);
    assign md_done   = r_done;
    assign md_is_div = r_is_div;

    // ---------------- saturating stall counter ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= 16'd0;
        end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cycles = r_stall_cnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt;
    logic        id_uses_rs, id_uses_rt;
    logic [1:0]  id_md_op;
    logic        id_md_read;
    logic        ex_wreg, ex_m2reg;
    logic [4:0]  ex_rd;
    logic        flush;
    logic        pc_we, ifid_we, idex_bubble, md_start, md_is_div, md_busy, md_done;
    logic [15:0] stall_cycles;

    int tests = 0;
    int fails = 0;

    hazard_stall_ctrl #(.MUL_LAT(4), .DIV_LAT(16), .CNT_W(5)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_md_op(id_md_op), .id_md_read(id_md_read),
        .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_rd(ex_rd),
        .flush(flush),
        .pc_we(pc_we), .ifid_we(ifid_we), .idex_bubble(idex_bubble),
        .md_start(md_start), .md_is_div(md_is_div), .md_busy(md_busy),
        .md_done(md_done), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; inputs change and outputs are sampled 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
        id_md_op = 2'b00; id_md_read = 0; ex_wreg = 0; ex_m2reg = 0; ex_rd = 0;
        flush = 0;
    endtask

    task automatic load_use_inputs();
        id_valid = 1; id_rs = 5'd5; id_uses_rs = 1; ex_wreg = 1; ex_m2reg = 1; ex_rd = 5'd5;
    endtask

    initial begin
        int seen_done;
        idle_inputs();
        rst = 1;
        #12;
        check("reset_busy", {15'd0, md_busy}, 16'd0);
        check("reset_done", {15'd0, md_done}, 16'd0);
        check("reset_isdiv", {15'd0, md_is_div}, 16'd0);
        check("reset_cnt", stall_cycles, 16'd0);
        check("reset_pcwe", {15'd0, pc_we}, 16'd1);
        step();
        rst = 0;
        step();

        // Load-use hit
        load_use_inputs();
        #1;
        check("lu_pcwe", {15'd0, pc_we}, 16'd0);
        check("lu_ifidwe", {15'd0, ifid_we}, 16'd0);
        check("lu_bubble", {15'd0, idex_bubble}, 16'd1);
        check("lu_cnt_before", stall_cycles, 16'd0);
        step();
        idle_inputs();
        #1;
        check("lu_cnt_after", stall_cycles, 16'd1);

        // r0 destination and rs not used: no stall
        load_use_inputs(); ex_rd = 5'd0; id_rs = 5'd0;
        #1;
        check("r0_pcwe", {15'd0, pc_we}, 16'd1);
        check("r0_bubble", {15'd0, idex_bubble}, 16'd0);
        load_use_inputs(); id_uses_rs = 0;
        #1;
        check("nouse_pcwe", {15'd0, pc_we}, 16'd1);
        // rt path hit
        load_use_inputs(); id_uses_rs = 0; id_uses_rt = 1; id_rt = 5'd5;
        #1;
        check("rt_pcwe", {15'd0, pc_we}, 16'd0);
        idle_inputs();
        #1;
        check("nostall_cnt", stall_cycles, 16'd1);

        // Mult launch
        id_valid = 1; id_md_op = 2'b01;
        #1;
        check("mul_start", {15'd0, md_start}, 16'd1);
        step();
        idle_inputs();
        for (int i = 1; i <= 4; i++) begin
            #1;
            check($sformatf("mul_busy_c%0d", i), {14'd0, md_busy, md_done}, 16'b10);
            step();
        end
        check("mul_done_c5", {14'd0, md_busy, md_done}, 16'b01);
        check("mul_isdiv", {15'd0, md_is_div}, 16'd0);
        step();
        check("mul_done_c6", {15'd0, md_done}, 16'd0);

        // Flush priority
        load_use_inputs(); flush = 1;
        #1;
        check("fl_pcwe", {15'd0, pc_we}, 16'd1);
        check("fl_bubble", {15'd0, idex_bubble}, 16'd1);
        step();
        check("fl_cnt", stall_cycles, 16'd1);
        idle_inputs(); id_valid = 1; id_md_op = 2'b01; flush = 1;
        #1;
        check("fl_mdstart", {15'd0, md_start}, 16'd0);
        step();
        idle_inputs();
        check("fl_idle", {15'd0, md_busy}, 16'd0);

        // Div plus dependent mfhi, starting from a cleared counter
        rst = 1;
        #1;
        check("rst_cnt_clear", stall_cycles, 16'd0);
        step();
        rst = 0;
        id_valid = 1; id_md_op = 2'b10;
        #1;
        check("div_start", {15'd0, md_start}, 16'd1);
        step();
        id_md_op = 2'b00; id_md_read = 1;
        for (int i = 1; i <= 16; i++) begin
            #1;
            check($sformatf("mfhi_stall_c%0d", i), {14'd0, md_busy, pc_we}, 16'b10);
            step();
        end
        check("div_done", {15'd0, md_done}, 16'd1);
        check("div_isdiv", {15'd0, md_is_div}, 16'd1);
        check("mfhi_go", {15'd0, pc_we}, 16'd1);
        check("div_cnt16", stall_cycles, 16'd16);
        // Back-to-back div in the md_done cycle
        id_md_read = 0; id_md_op = 2'b10;
        #1;
        check("b2b_start", {14'd0, md_start, pc_we}, 16'b11);
        step();
        idle_inputs();
        check("b2b_busy", {14'd0, md_busy, md_done}, 16'b10);

        // Reset mid-div at busy cycle 7
        repeat (6) step();
        check("pre_rst_busy", {15'd0, md_busy}, 16'd1);
        rst = 1;
        #1;
        check("mid_rst_busy", {15'd0, md_busy}, 16'd0);
        check("mid_rst_cnt", stall_cycles, 16'd0);
        step();
        rst = 0;
        seen_done = 0;
        repeat (20) begin
            step();
            if (md_done) seen_done++;
        end
        check("no_done_after_rst", seen_done[15:0], 16'd0);

        // Saturation
        load_use_inputs();
        repeat (70000) @(posedge clk);
        #1;
        check("sat_cnt", stall_cycles, 16'hFFFF);
        check("sat_pcwe", {15'd0, pc_we}, 16'd0);
        idle_inputs();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
